// File: rtl/regfile_pkg.sv
// Shared register-file definitions: address/data widths, the zero register and
// the write-request record used by every writer of the 32x32 register file.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // r0 is hardwired to zero, so any write aimed at it is a no-op.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/regfile_wb_fifo.sv
// Synchronous FIFO of register-file write requests (module wb_fifo) that also
// exposes per-entry valid/address vectors so the owner can search it for hazards.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             push,
  input  wb_req_t                          push_req,
  input  logic                             pop,
  output wb_req_t                          head,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH):0]           count,
  output logic [DEPTH-1:0]                 entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]     entry_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides which
  // entries are meaningful, and leaving the array unreset keeps it RAM-friendly.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // An entry is live when its distance from the read pointer is below occupancy.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    logic [PTR_W-1:0] offset;
    offset      = '0;
    entry_valid = '0;
    entry_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PTR_W'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, offset} < count);
      entry_addr[i]  = mem[i].addr;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file: pipeline writeback has absolute
// priority, auxiliary writes queue in wb_fifo. Optional WB_FORWARD_EN adds bypass ports.
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = regfile_pkg::DATA_W,
  parameter int ADDR_W       = regfile_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_data,
  input  logic [ADDR_W-1:0] read_register_1,
  input  logic [ADDR_W-1:0] read_register_2,
  output logic              busy_1,
  output logic              busy_2,
  output logic              stall_pipe,
  output logic              reg_write_enable,
  output logic [ADDR_W-1:0] reg_write_address,
  output logic [DATA_W-1:0] write_data
`ifdef WB_FORWARD_EN
  ,
  output logic              fwd_valid_1,
  output logic              fwd_valid_2,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic [DATA_W-1:0] fwd_data_2
`endif
);

  import regfile_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic                                pipe_eff;
  logic                                push;
  logic                                pop;
  logic                                fifo_full;
  logic                                fifo_empty;
  logic [CNT_W-1:0]                    fifo_count;
  wb_req_t                             aux_req;
  wb_req_t                             head;
  logic [FIFO_DEPTH-1:0]               entry_valid;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0]   entry_addr;
  logic [SC_W-1:0]                     starve_cnt;
  logic [SC_W-1:0]                     starve_next;

  // A pipeline write to r0 is dropped entirely and leaves the port to the queue.
  assign pipe_eff  = pipe_we && !is_zero_reg(pipe_addr);
  assign aux_ready = !fifo_full;
  assign push      = aux_valid && aux_ready;
  assign pop       = !pipe_eff && !fifo_empty;
  assign aux_req   = '{addr: aux_addr, data: aux_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (Reset),
    .push        (push),
    .push_req    (aux_req),
    .pop         (pop),
    .head        (head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // The head being popped this cycle is still live in the FIFO, so it still flags busy.
  always_comb begin
    busy_1 = 1'b0;
    busy_2 = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i] && entry_addr[i] == read_register_1) busy_1 = 1'b1;
      if (entry_valid[i] && entry_addr[i] == read_register_2) busy_2 = 1'b1;
    end
    if (is_zero_reg(read_register_1)) busy_1 = 1'b0;
    if (is_zero_reg(read_register_2)) busy_2 = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      reg_write_enable  <= 1'b0;
      reg_write_address <= '0;
      write_data        <= '0;
    end else if (pipe_eff) begin
      reg_write_enable  <= 1'b1;
      reg_write_address <= pipe_addr;
      write_data        <= pipe_data;
    end else if (pop) begin
      reg_write_enable  <= !is_zero_reg(head.addr);
      reg_write_address <= head.addr;
      write_data        <= head.data;
    end else begin
      reg_write_enable  <= 1'b0;
    end
  end

  // Counts consecutive cycles the queue loses to the pipeline; any pop resets it.
  always_comb begin
    starve_next = starve_cnt;
    if (pop || fifo_count == '0) begin
      starve_next = '0;
    end else if (pipe_eff && starve_cnt != STARVE_MAX) begin
      starve_next = starve_cnt + SC_W'(1);
    end
  end

  // stall_pipe follows the counter's next value so it rises the cycle after the limit is hit.
  always_ff @(posedge clock) begin
    if (Reset) begin
      starve_cnt <= '0;
      stall_pipe <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      stall_pipe <= (starve_next == STARVE_MAX);
    end
  end

`ifdef WB_FORWARD_EN
  assign fwd_valid_1 = reg_write_enable && reg_write_address == read_register_1 &&
                       !is_zero_reg(read_register_1);
  assign fwd_valid_2 = reg_write_enable && reg_write_address == read_register_2 &&
                       !is_zero_reg(read_register_2);
  assign fwd_data_1  = write_data;
  assign fwd_data_2  = write_data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; forwarding checks are
// compiled in only when WB_FORWARD_EN is defined.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        Reset;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic [4:0]  read_register_1;
  logic [4:0]  read_register_2;
  logic        busy_1;
  logic        busy_2;
  logic        stall_pipe;
  logic        reg_write_enable;
  logic [4:0]  reg_write_address;
  logic [31:0] write_data;
`ifdef WB_FORWARD_EN
  logic        fwd_valid_1;
  logic        fwd_valid_2;
  logic [31:0] fwd_data_1;
  logic [31:0] fwd_data_2;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  regfile_wb_arbiter dut (
    .clock             (clock),
    .Reset             (Reset),
    .pipe_we           (pipe_we),
    .pipe_addr         (pipe_addr),
    .pipe_data         (pipe_data),
    .aux_valid         (aux_valid),
    .aux_ready         (aux_ready),
    .aux_addr          (aux_addr),
    .aux_data          (aux_data),
    .read_register_1   (read_register_1),
    .read_register_2   (read_register_2),
    .busy_1            (busy_1),
    .busy_2            (busy_2),
    .stall_pipe        (stall_pipe),
    .reg_write_enable  (reg_write_enable),
    .reg_write_address (reg_write_address),
    .write_data        (write_data)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid_1       (fwd_valid_1),
    .fwd_valid_2       (fwd_valid_2),
    .fwd_data_1        (fwd_data_1),
    .fwd_data_2        (fwd_data_2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_pipe(input logic we, input logic [4:0] addr, input logic [31:0] data);
    pipe_we   = we;
    pipe_addr = addr;
    pipe_data = data;
  endtask

  task automatic set_aux(input logic v, input logic [4:0] addr, input logic [31:0] data);
    aux_valid = v;
    aux_addr  = addr;
    aux_data  = data;
  endtask

  task automatic check_write(input string tag, input logic en, input logic [4:0] addr,
                             input logic [31:0] data);
    check({tag, ".en"},   32'(reg_write_enable),  32'(en));
    check({tag, ".addr"}, 32'(reg_write_address), 32'(addr));
    check({tag, ".data"}, write_data,             data);
  endtask

  initial begin
    Reset = 1'b1;
    set_pipe(1'b0, 5'd0, 32'h0);
    set_aux(1'b0, 5'd0, 32'h0);
    read_register_1 = 5'd10;
    read_register_2 = 5'd0;

    // Reset state
    tick();
    tick();
    check_write("rst", 1'b0, 5'd0, 32'h0);
    check("rst.stall", 32'(stall_pipe), 32'd0);
    check("rst.ready", 32'(aux_ready), 32'd1);
    check("rst.busy1", 32'(busy_1), 32'd0);
    Reset = 1'b0;

    // Queue three aux writes behind a busy pipeline, then reset mid-operation
    set_pipe(1'b1, 5'd1, 32'h11);
    for (int i = 0; i < 3; i++) begin
      set_aux(1'b1, 5'(10 + i), 32'h100 + 32'(i));
      tick();
    end
    set_aux(1'b0, 5'd0, 32'h0);
    settle();
    check("q3.ready", 32'(aux_ready), 32'd1);
    check("q3.busy1", 32'(busy_1), 32'd1);
    Reset = 1'b1;
    tick();
    check("midrst.en", 32'(reg_write_enable), 32'd0);
    check("midrst.ready", 32'(aux_ready), 32'd1);
    check("midrst.busy1", 32'(busy_1), 32'd0);
    check("midrst.stall", 32'(stall_pipe), 32'd0);
    Reset = 1'b0;
    set_pipe(1'b0, 5'd0, 32'h0);
    tick();
    check("midrst.drain_en", 32'(reg_write_enable), 32'd0);

    // Pipeline-only writes; r0 writes are ignored and the port holds
    set_pipe(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check_write("pipe5", 1'b1, 5'd5, 32'hDEADBEEF);
    set_pipe(1'b1, 5'd0, 32'h55);
    tick();
    check_write("pipe_r0", 1'b0, 5'd5, 32'hDEADBEEF);
    set_pipe(1'b1, 5'd7, 32'h7777_0007);
    read_register_2 = 5'd7;
    tick();
    check_write("pipe7", 1'b1, 5'd7, 32'h7777_0007);
`ifdef WB_FORWARD_EN
    check("fwd.valid2", 32'(fwd_valid_2), 32'd1);
    check("fwd.data2", fwd_data_2, 32'h7777_0007);
    check("fwd.valid1", 32'(fwd_valid_1), 32'd0);
`endif

    // Aux latency and busy: accepted, popped next cycle, written the cycle after
    set_pipe(1'b0, 5'd0, 32'h0);
    read_register_1 = 5'd9;
    read_register_2 = 5'd0;
    set_aux(1'b1, 5'd9, 32'h1234);
    settle();
    check("aux.busy_pre", 32'(busy_1), 32'd0);
    tick();
    set_aux(1'b0, 5'd0, 32'h0);
    settle();
    check("aux.busy_q", 32'(busy_1), 32'd1);
    check("aux.no_fallthru", 32'(reg_write_enable), 32'd0);
    tick();
    check_write("aux.write", 1'b1, 5'd9, 32'h1234);
    settle();
    check("aux.busy_post", 32'(busy_1), 32'd0);

    // Fill under continuous pipeline traffic, then drain in order
    set_pipe(1'b1, 5'd3, 32'h33);
    for (int i = 0; i < 4; i++) begin
      set_aux(1'b1, 5'(20 + i), 32'hA0 + 32'(i));
      tick();
    end
    set_aux(1'b1, 5'd24, 32'hA4);
    read_register_1 = 5'd25;
    read_register_2 = 5'd22;
    settle();
    check("full.ready", 32'(aux_ready), 32'd0);
    check("full.busy2", 32'(busy_2), 32'd1);
    check("full.busy1", 32'(busy_1), 32'd0);
    tick();
    check_write("full.pipe", 1'b1, 5'd3, 32'h33);
    check("full.stall", 32'(stall_pipe), 32'd1);
    check("full.ready_hold", 32'(aux_ready), 32'd0);
    set_pipe(1'b0, 5'd0, 32'h0);
    settle();
    check("full.ready_on_pop", 32'(aux_ready), 32'd0);
    tick();
    check_write("drain0", 1'b1, 5'd20, 32'hA0);
    check("drain.stall_clr", 32'(stall_pipe), 32'd0);
    settle();
    check("drain.ready", 32'(aux_ready), 32'd1);
    tick();
    set_aux(1'b0, 5'd0, 32'h0);
    check_write("drain1", 1'b1, 5'd21, 32'hA1);
    tick();
    check_write("drain2", 1'b1, 5'd22, 32'hA2);
    tick();
    check_write("drain3", 1'b1, 5'd23, 32'hA3);
    tick();
    check_write("drain4", 1'b1, 5'd24, 32'hA4);
    tick();
    check("drain.idle", 32'(reg_write_enable), 32'd0);

    // Starvation: one queued entry loses four cycles to the pipeline
    set_pipe(1'b1, 5'd2, 32'h22);
    set_aux(1'b1, 5'd14, 32'h77);
    tick();
    set_aux(1'b0, 5'd0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 3) check("starve.c3", 32'(stall_pipe), 32'd0);
      if (c == 4) check("starve.c4", 32'(stall_pipe), 32'd1);
    end
    set_pipe(1'b0, 5'd0, 32'h0);
    tick();
    check_write("starve.pop", 1'b1, 5'd14, 32'h77);
    check("starve.clr", 32'(stall_pipe), 32'd0);

    // Queued r0 write is consumed without a write; r0 never reads busy
    read_register_1 = 5'd0;
    read_register_2 = 5'd0;
    set_aux(1'b1, 5'd0, 32'hFFFF);
    tick();
    set_aux(1'b0, 5'd0, 32'h0);
    settle();
    check("r0.busy1", 32'(busy_1), 32'd0);
    check("r0.busy2", 32'(busy_2), 32'd0);
    tick();
    check_write("r0.pop", 1'b0, 5'd0, 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
